// File: rtl/alg_ctrl_pkg.sv
// Shared types for the QRS record sequencer: FSM state encoding and the RR
// result record carried through the result FIFO.
package alg_ctrl_pkg;

  localparam int CTR_WIDTH_DEF = 22;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    DRAIN,
    DONE
  } seq_state_t;

  typedef struct packed {
    logic [CTR_WIDTH_DEF-1:0] rr_period;
    logic [CTR_WIDTH_DEF-1:0] peak_num;
  } rr_entry_t;

endpackage

// File: rtl/rr_fifo.sv
// First-word-fall-through FIFO of RR records; head is valid whenever !empty.
module rr_fifo
  import alg_ctrl_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic      i_clk,
  input  logic      i_rst,
  input  logic      push,
  input  rr_entry_t wdata,
  input  logic      pop,
  input  logic      flush,
  output logic      full,
  output logic      empty,
  output rr_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  rr_entry_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  // Extra pointer bit distinguishes full from empty when indices match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alg_seq_ctrl.sv
// Record sequencer for the QRS core: clears the core, meters samples in,
// drains the pipeline, and turns R-peak strobes into queued RR records.
module alg_seq_ctrl
  import alg_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH   = 11,
  parameter int CTR_WIDTH    = 22,
  parameter int CLR_CYCLES   = 4,
  parameter int DRAIN_CYCLES = 64,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [CTR_WIDTH-1:0]  i_rec_len,
  output logic                  o_busy,
  output logic                  o_done,
  input  logic                  i_smp_valid,
  output logic                  o_smp_ready,
  input  logic [DATA_WIDTH-1:0] i_smp_data,
  output logic                  o_core_nrst,
  output logic                  o_core_ce,
  output logic                  o_core_data_valid,
  output logic [DATA_WIDTH-1:0] o_core_ecg_value,
  input  logic                  i_core_peak,
  input  logic [CTR_WIDTH-1:0]  i_core_peak_num,
  output logic                  o_rr_valid,
  input  logic                  i_rr_ready,
  output logic [CTR_WIDTH-1:0]  o_rr_period,
  output logic [CTR_WIDTH-1:0]  o_rr_peak_num,
  output logic                  o_overflow,
  output logic [CTR_WIDTH-1:0]  o_peak_cnt
);

  localparam int CLR_W = $clog2(CLR_CYCLES + 1);
  localparam int DRN_W = $clog2(DRAIN_CYCLES + 1);

  seq_state_t            state_q, state_d;
  logic [CTR_WIDTH-1:0]  rec_len_q, rec_len_d;
  logic [CTR_WIDTH-1:0]  acc_q, acc_d;
  logic [CTR_WIDTH-1:0]  acc_inc;
  logic [CTR_WIDTH-1:0]  last_peak_q, last_peak_d;
  logic [CTR_WIDTH-1:0]  peak_cnt_q, peak_cnt_d;
  logic                  have_last_q, have_last_d;
  logic [CLR_W-1:0]      clr_cnt_q, clr_cnt_d;
  logic [DRN_W-1:0]      drn_cnt_q, drn_cnt_d;
  logic                  nrst_q, nrst_d;
  logic                  ce_q, ce_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  dv_q, dv_d;
  logic                  abort_q, abort_d;
  logic                  ovf_q, ovf_d;
  logic [DATA_WIDTH-1:0] ecg_q, ecg_d;

  logic                  smp_ready, accept, peak_ok;
  logic                  fifo_push, fifo_flush, fifo_full, fifo_empty;
  rr_entry_t             push_entry, head_entry;

  assign smp_ready = (state_q == RUN) && (acc_q < rec_len_q);
  assign accept    = i_smp_valid && smp_ready;
  assign peak_ok   = i_core_peak && !i_abort && ((state_q == RUN) || (state_q == DRAIN));
  assign acc_inc   = acc_q + CTR_WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    rec_len_d   = rec_len_q;
    acc_d       = acc_q;
    last_peak_d = last_peak_q;
    peak_cnt_d  = peak_cnt_q;
    have_last_d = have_last_q;
    clr_cnt_d   = clr_cnt_q;
    drn_cnt_d   = drn_cnt_q;
    nrst_d      = nrst_q;
    ovf_d       = ovf_q;
    ecg_d       = ecg_q;
    dv_d        = 1'b0;
    abort_d     = i_abort;
    fifo_flush  = 1'b0;
    fifo_push   = 1'b0;
    push_entry  = '0;

    unique case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          state_d     = CLEAR;
          rec_len_d   = i_rec_len;
          acc_d       = '0;
          peak_cnt_d  = '0;
          have_last_d = 1'b0;
          ovf_d       = 1'b0;
          clr_cnt_d   = '0;
          nrst_d      = 1'b0;
          fifo_flush  = 1'b1;
        end else if (abort_q) begin
          // Abort reset pulse is one cycle; release the core afterwards.
          nrst_d = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
          nrst_d    = 1'b1;
          drn_cnt_d = '0;
          state_d   = (rec_len_q == '0) ? DRAIN : RUN;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      RUN: begin
        if (accept) begin
          ecg_d = i_smp_data;
          dv_d  = 1'b1;
          acc_d = acc_inc;
          if (acc_inc == rec_len_q) begin
            state_d   = DRAIN;
            drn_cnt_d = '0;
          end
        end
      end
      DRAIN: begin
        if (drn_cnt_q == DRN_W'(DRAIN_CYCLES - 1)) state_d = DONE;
        else drn_cnt_d = drn_cnt_q + DRN_W'(1);
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (peak_ok) begin
      if (peak_cnt_q != '1) peak_cnt_d = peak_cnt_q + CTR_WIDTH'(1);
      if (have_last_q) begin
        fifo_push            = 1'b1;
        push_entry.rr_period = CTR_WIDTH_DEF'(i_core_peak_num - last_peak_q);
        push_entry.peak_num  = CTR_WIDTH_DEF'(i_core_peak_num);
        // A full FIFO accepts the push only when the host pops in the same cycle.
        if (fifo_full && !i_rr_ready) ovf_d = 1'b1;
      end
      last_peak_d = i_core_peak_num;
      have_last_d = 1'b1;
    end

    if (i_abort) begin
      state_d    = IDLE;
      nrst_d     = 1'b0;
      dv_d       = 1'b0;
      fifo_flush = 1'b1;
    end

    ce_d   = (state_d == CLEAR) || (state_d == RUN) || (state_d == DRAIN);
    busy_d = ce_d;
    done_d = (state_d == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      rec_len_q   <= '0;
      acc_q       <= '0;
      last_peak_q <= '0;
      peak_cnt_q  <= '0;
      have_last_q <= 1'b0;
      clr_cnt_q   <= '0;
      drn_cnt_q   <= '0;
      nrst_q      <= 1'b0;
      ce_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      dv_q        <= 1'b0;
      abort_q     <= 1'b0;
      ovf_q       <= 1'b0;
      ecg_q       <= '0;
    end else begin
      state_q     <= state_d;
      rec_len_q   <= rec_len_d;
      acc_q       <= acc_d;
      last_peak_q <= last_peak_d;
      peak_cnt_q  <= peak_cnt_d;
      have_last_q <= have_last_d;
      clr_cnt_q   <= clr_cnt_d;
      drn_cnt_q   <= drn_cnt_d;
      nrst_q      <= nrst_d;
      ce_q        <= ce_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      dv_q        <= dv_d;
      abort_q     <= abort_d;
      ovf_q       <= ovf_d;
      ecg_q       <= ecg_d;
    end
  end

  rr_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_rr_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (i_rr_ready),
    .flush (fifo_flush),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_entry)
  );

  assign o_busy            = busy_q;
  assign o_done            = done_q;
  assign o_smp_ready       = smp_ready;
  assign o_core_nrst       = nrst_q;
  assign o_core_ce         = ce_q;
  assign o_core_data_valid = dv_q;
  assign o_core_ecg_value  = ecg_q;
  assign o_rr_valid        = !fifo_empty;
  assign o_rr_period       = CTR_WIDTH'(head_entry.rr_period);
  assign o_rr_peak_num     = CTR_WIDTH'(head_entry.peak_num);
  assign o_overflow        = ovf_q;
  assign o_peak_cnt        = peak_cnt_q;

endmodule
